addsub_seq_nb: RTL and testbench

- Parametrised multi-cycle adder/subtractor that generalises the team's 2-bit ripple full-adder chain.
- Processes DIGIT bits per clock through a DIGIT-bit full-adder slice, with the carry held in a flop between cycles.
- Adds start/busy/done handshaking, a subtract mode and a signed-overflow flag.
- Sits in the arithmetic datapath where area matters more than single-cycle latency.

---
 rtl/addsub_seq_nb.sv | 148 ++++++++++++++
 tb/tb_addsub_seq_nb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq_nb.sv
// Digit-serial adder/subtractor. Each RUN cycle one DIGIT-bit full-adder slice
// consumes the low digit of the operand shift registers, and the carry is held
// in a flop between cycles. A result takes N = WIDTH/DIGIT RUN cycles.
//
// Ports:
//   clk    - rising-edge clock
//   rst_b  - asynchronous active-low reset
//   start  - request; accepted only in IDLE or DONE
//   sub    - 0 = add, 1 = subtract (latched at start)
//   x, y   - operands A and B (latched at start)
//   ci     - carry-in (add) or borrow-in (sub) (latched at start)
//   sum    - result, held from done until the next accepted start
//   co     - carry-out; in subtract mode 1 means no borrow
//   ovf    - two's-complement signed overflow
//   busy   - high while the operation runs
//   done   - one-cycle pulse when the result is valid
module addsub_seq_nb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   slice;
    logic [DIGIT-1:0] s;
    logic             c;
    logic             c_msb;
    logic [WIDTH-1:0] full;   // new digit joined with the partial result so far
    logic             run;

    assign run   = (state_q == StRun);
    assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
    assign s     = slice[DIGIT-1:0];
    assign c     = slice[DIGIT];
    // Carry into the slice MSB recovered from its sum bit; equals carry_q when DIGIT=1.
    assign c_msb = s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    // Partial results accumulate in a shadow register so sum only changes on entry to DONE.
    if (DIGIT < WIDTH) begin : g_shadow
        logic [WIDTH-DIGIT-1:0] shadow_q, shadow_d;

        assign full     = {s, shadow_q};
        assign shadow_d = run ? full[WIDTH-1:DIGIT] : shadow_q;

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                shadow_q <= '0;
            end else begin
                shadow_q <= shadow_d;
            end
        end
    end else begin : g_no_shadow
        assign full = s;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = x;
                    b_d     = sub ? ~y : y;
                    carry_d = ci ^ sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    sum_d   = full;
                    co_d    = c;
                    ovf_d   = c ^ c_msb;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
    assign busy = run;
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_addsub_seq_nb.sv
// Bench for addsub_seq_nb: three instances (8/2, 4/1, 8/8) share operand inputs.
// Expected {co, ovf, sum} words are queued at issue; per-instance monitors pop on done.
module tb_addsub_seq_nb;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [2:0] start_v;
    logic       sub;
    logic       ci;
    logic [7:0] x;
    logic [7:0] y;

    logic [7:0] sum0;
    logic [3:0] sum1;
    logic [7:0] sum2;
    logic [2:0] co_v, ovf_v, busy_v, done_v;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addsub_seq_nb #(.WIDTH(8), .DIGIT(2)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .start(start_v[0]), .sub(sub), .x(x), .y(y), .ci(ci),
        .sum(sum0), .co(co_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    addsub_seq_nb #(.WIDTH(4), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .start(start_v[1]), .sub(sub), .x(x[3:0]), .y(y[3:0]),
        .ci(ci), .sum(sum1), .co(co_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]),
        .done(done_v[1])
    );

    addsub_seq_nb #(.WIDTH(8), .DIGIT(8)) u_dut2 (
        .clk(clk), .rst_b(rst_b), .start(start_v[2]), .sub(sub), .x(x), .y(y), .ci(ci),
        .sum(sum2), .co(co_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Monitors: compare on every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (done_v[0]) begin
            if (q0.size() == 0) chk("dut0_unexpected_done", 32'd1, 32'd0);
            else chk("dut0_result", {22'd0, co_v[0], ovf_v[0], sum0}, {22'd0, q0.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (done_v[1]) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
            else chk("dut1_result", {22'd0, co_v[1], ovf_v[1], 4'd0, sum1},
                     {22'd0, q1.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (done_v[2]) begin
            if (q2.size() == 0) chk("dut2_unexpected_done", 32'd1, 32'd0);
            else chk("dut2_result", {22'd0, co_v[2], ovf_v[2], sum2}, {22'd0, q2.pop_front()});
        end
    end

    // Called at a negedge: drive operands, raise start and queue the expectation.
    task automatic issue(input int sel, input logic [7:0] xa, input logic [7:0] ya,
                         input logic cia, input logic suba, input logic [9:0] exp_v);
        x = xa;
        y = ya;
        ci = cia;
        sub = suba;
        start_v = '0;
        start_v[sel] = 1'b1;
        case (sel)
            0:       q0.push_back(exp_v);
            1:       q1.push_back(exp_v);
            default: q2.push_back(exp_v);
        endcase
    endtask

    // Drop start after the start edge, then measure edges-to-done and busy cycles.
    task automatic finish_op(input int sel);
        int k;
        int nb;
        int n_exp;
        n_exp = (sel == 2) ? 1 : 4;
        @(negedge clk);
        start_v = '0;
        k = 0;
        nb = 0;
        while (!done_v[sel] && k < 20) begin
            if (busy_v[sel]) nb++;
            @(negedge clk);
            k++;
        end
        chk($sformatf("latency_dut%0d", sel), k, n_exp);
        chk($sformatf("busy_cycles_dut%0d", sel), nb, n_exp);
    endtask

    task automatic do_op(input int sel, input logic [7:0] xa, input logic [7:0] ya,
                         input logic cia, input logic suba, input logic [9:0] exp_v);
        @(negedge clk);
        issue(sel, xa, ya, cia, suba, exp_v);
        finish_op(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nd;
        rst_b = 1'b0;
        start_v = '0;
        sub = 1'b0;
        ci = 1'b0;
        x = '0;
        y = '0;
        #12;
        chk("reset_flags", {busy_v, done_v, co_v, ovf_v}, 12'd0);
        chk("reset_sums", {sum0, sum1, sum2}, 20'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // Expected words are {co, ovf, sum}.
        do_op(0, 8'hA5, 8'h3C, 1'b0, 1'b0, {2'b00, 8'hE1});
        do_op(0, 8'h10, 8'h20, 1'b0, 1'b1, {2'b00, 8'hF0});
        do_op(0, 8'h20, 8'h10, 1'b0, 1'b1, {2'b10, 8'h10});
        do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, {2'b01, 8'h80});
        do_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, {2'b10, 8'h01});

        // start pulsed during RUN with different operands must be ignored.
        @(negedge clk);
        issue(0, 8'hA5, 8'h3C, 1'b0, 1'b0, {2'b00, 8'hE1});
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        x = 8'hFF;
        y = 8'hFF;
        sub = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        k = 2;
        while (!done_v[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("run_start_latency", k, 4);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("run_start_single_done", nd, 0);

        // Back-to-back: start held in DONE goes straight to RUN.
        do_op(0, 8'h11, 8'h22, 1'b0, 1'b0, {2'b00, 8'h33});
        issue(0, 8'h01, 8'h02, 1'b0, 1'b0, {2'b00, 8'h03});
        finish_op(0);

        // Asynchronous reset between E2 and E3 aborts the operation.
        do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, {2'b01, 8'h80});
        @(negedge clk);
        issue(0, 8'h55, 8'h22, 1'b0, 1'b0, {2'b00, 8'h77});
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk("midreset_outputs", {busy_v[0], done_v[0], co_v[0], ovf_v[0], sum0}, 12'd0);
        q0.delete();
        @(negedge clk);
        rst_b = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        chk("midreset_no_done", nd, 0);
        do_op(0, 8'hA5, 8'h3C, 1'b0, 1'b0, {2'b00, 8'hE1});

        // Parameter sweep.
        do_op(1, 8'h0B, 8'h06, 1'b1, 1'b0, {2'b10, 8'h02});
        do_op(2, 8'hA5, 8'h3C, 1'b0, 1'b0, {2'b00, 8'hE1});
        do_op(2, 8'h80, 8'h01, 1'b0, 1'b1, {2'b11, 8'h7F});

        repeat (3) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        chk("queue2_drained", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
